// File: rtl/sink_pkg.sv
// ============================================================================
// Module : sink_pkg
// Brief  : Shared state encoding and defaults for the sink-table search block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sink_pkg;

    localparam int unsigned c_word_w_def   = 16;
    localparam logic [15:0] c_sentinel_def = 16'hFFFF;

    localparam int unsigned c_state_w = 3;
    localparam logic [c_state_w-1:0] c_st_idle  = 3'd0;
    localparam logic [c_state_w-1:0] c_st_fetch = 3'd1;
    localparam logic [c_state_w-1:0] c_st_wait  = 3'd2;
    localparam logic [c_state_w-1:0] c_st_cmp   = 3'd3;
    localparam logic [c_state_w-1:0] c_st_done  = 3'd4;

    // Index width never drops below one bit, even for a single-entry table.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sink_table_search_if.sv
// ============================================================================
// Module : sink_table_search_if
// Brief  : Control, key and memory-read bundle of the sink-table search block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sink_table_search_if #(
    parameter int WORD_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int NUM_ENTRIES = 16
);
    import sink_pkg::*;

    localparam int IDX_W = idx_width(NUM_ENTRIES);

    logic              start;
    logic              abort;
    logic [WORD_W-1:0] key;
    logic [WORD_W-1:0] data_in;
    logic [ADDR_W-1:0] address;
    logic              busy;
    logic              done;
    logic              found;
    logic [IDX_W-1:0]  match_idx;

    modport master (
        output start, abort, key, data_in,
        input  address, busy, done, found, match_idx
    );

    modport slave (
        input  start, abort, key, data_in,
        output address, busy, done, found, match_idx
    );

endinterface

`default_nettype wire

// File: rtl/sink_addr_gen.sv
// ============================================================================
// Module : sink_addr_gen
// Brief  : Entry index counter and BASE_ADDR + idx*STRIDE address register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sink_addr_gen #(
    parameter int ADDR_W    = 16,
    parameter int IDX_W     = 4,
    parameter int STRIDE    = 2,
    parameter int BASE_ADDR = 0
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              load,
    input  wire logic              inc,
    output logic      [IDX_W-1:0]  idx,
    output logic      [ADDR_W-1:0] address
);

    localparam logic [ADDR_W-1:0] c_base   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_stride = ADDR_W'(STRIDE);

    logic [IDX_W-1:0]  w_idx_next;
    logic [ADDR_W-1:0] w_addr_next;

    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign w_idx_next  = idx + IDX_W'(1);
    assign w_addr_next = c_base + ADDR_W'(w_idx_next) * c_stride;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            address <= c_base;
        end else if (load) begin
            idx     <= '0;
            address <= c_base;
        end else if (inc) begin
            idx     <= w_idx_next;
            address <= w_addr_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sink_table_search.sv
// ============================================================================
// Module : sink_table_search
// Brief  : Start-triggered scan of the known-sinks table for a latched key.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sink_table_search
    import sink_pkg::*;
#(
    parameter int                WORD_W           = c_word_w_def,
    parameter int                ADDR_W           = 16,
    parameter int                NUM_ENTRIES      = 16,
    parameter int                STRIDE           = 2,
    parameter int                BASE_ADDR        = 0,
    parameter int                RD_LAT           = 1,
    parameter logic [WORD_W-1:0] SENTINEL         = WORD_W'(c_sentinel_def),
    parameter int                STOP_ON_SENTINEL = 1
) (
    input wire logic         clock,
    input wire logic         reset,
    sink_table_search_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [2:0]       c_wait_last = 3'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

    logic [c_state_w-1:0] r_state, w_state_next;
    logic [2:0]           r_wait_cnt;
    logic [WORD_W-1:0]    r_key;
    logic                 r_busy, r_done, r_found;
    logic [IDX_W-1:0]     r_match_idx;
    logic [IDX_W-1:0]     w_idx;
    logic [ADDR_W-1:0]    w_address;
    logic                 w_busy_st, w_cmp_now, w_accept;
    logic                 w_is_sent, w_hit, w_last, w_end;
    logic                 w_load, w_inc, w_set_found, w_clear;

    sink_addr_gen #(
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W),
        .STRIDE    (STRIDE),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .load    (w_load),
        .inc     (w_inc),
        .idx     (w_idx),
        .address (w_address)
    );

    assign w_busy_st = (r_state == c_st_fetch) || (r_state == c_st_wait) || (r_state == c_st_cmp);
    // With zero read latency the data belongs to the address presented this cycle.
    assign w_cmp_now = (r_state == c_st_cmp) || ((RD_LAT == 0) && (r_state == c_st_fetch));
    assign w_accept  = bus.start && !bus.abort && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_is_sent = (STOP_ON_SENTINEL != 0) && (bus.data_in == SENTINEL);
    assign w_hit     = (bus.data_in == r_key);
    assign w_last    = (w_idx == c_last_idx);
    assign w_end     = w_is_sent || w_hit || w_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (w_accept) begin
                    w_state_next = c_st_fetch;
                end
            end
            c_st_fetch, c_st_wait, c_st_cmp: begin
                if (bus.abort) begin
                    w_state_next = c_st_idle;
                end else if (w_cmp_now) begin
                    w_state_next = w_end ? c_st_done : c_st_fetch;
                end else if (r_state == c_st_fetch) begin
                    w_state_next = (RD_LAT <= 1) ? c_st_cmp : c_st_wait;
                end else if ((r_state == c_st_wait) && (r_wait_cnt == c_wait_last)) begin
                    w_state_next = c_st_cmp;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_load      = w_accept;
        w_inc       = w_cmp_now && !bus.abort && !w_end;
        // Sentinel outranks a key match, so a key equal to SENTINEL is never reported.
        w_set_found = w_cmp_now && !bus.abort && !w_is_sent && w_hit;
        w_clear     = w_accept || (w_busy_st && bus.abort);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != c_st_wait) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_key       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_match_idx <= '0;
        end else begin
            if (w_load) begin
                r_key <= bus.key;
            end
            r_busy <= (w_state_next == c_st_fetch) || (w_state_next == c_st_wait) ||
                      (w_state_next == c_st_cmp);
            r_done <= (w_state_next == c_st_done);
            if (w_clear) begin
                r_found     <= 1'b0;
                r_match_idx <= '0;
            end else if (w_set_found) begin
                r_found     <= 1'b1;
                r_match_idx <= w_idx;
            end
        end
    end

    assign bus.address   = w_address;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.found     = r_found;
    assign bus.match_idx = r_match_idx;

endmodule

`default_nettype wire

// File: tb/tb_sink_table_search.sv
// ============================================================================
// Module : tb_sink_table_search
// Brief  : Directed bench for sink_table_search at read latencies 0, 1 and 3.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sink_table_search;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] key   = 16'h0000;
    logic [15:0] mem [16];

    int          checks = 0;
    int          errors = 0;
    int          pres_n;
    logic [15:0] pres_addr [16];
    logic        busy_c1, done_c1;

    always #5 clock = ~clock;

    sink_table_search_if #(.WORD_W(16), .ADDR_W(16), .NUM_ENTRIES(16)) b0 ();
    sink_table_search_if #(.WORD_W(16), .ADDR_W(16), .NUM_ENTRIES(16)) b1 ();
    sink_table_search_if #(.WORD_W(16), .ADDR_W(16), .NUM_ENTRIES(16)) b3 ();

    sink_table_search #(.RD_LAT(0)) u_dut_l0 (.clock(clock), .reset(reset), .bus(b0.slave));
    sink_table_search #(.RD_LAT(1)) u_dut_l1 (.clock(clock), .reset(reset), .bus(b1.slave));
    sink_table_search #(.RD_LAT(3)) u_dut_l3 (.clock(clock), .reset(reset), .bus(b3.slave));

    assign b0.start = start;  assign b0.abort = abort;  assign b0.key = key;
    assign b1.start = start;  assign b1.abort = abort;  assign b1.key = key;
    assign b3.start = start;  assign b3.abort = abort;  assign b3.key = key;

    // Memory models: data for an address appears RD_LAT cycles after it.
    logic [15:0] a1_d = 16'h0000;
    logic [15:0] a3_d [3] = '{16'h0000, 16'h0000, 16'h0000};
    always @(posedge clock) begin
        a1_d    <= b1.address;
        a3_d[0] <= b3.address;
        a3_d[1] <= a3_d[0];
        a3_d[2] <= a3_d[1];
    end
    assign b0.data_in = mem[b0.address[4:1]];
    assign b1.data_in = mem[a1_d[4:1]];
    assign b3.data_in = mem[a3_d[2][4:1]];

    // Index 0 -> RD_LAT 0, 1 -> RD_LAT 1, 2 -> RD_LAT 3.
    logic [2:0]  busy_w, done_w, found_w;
    logic [15:0] addr_w [3];
    logic [3:0]  idx_w  [3];
    assign busy_w  = {b3.busy,  b1.busy,  b0.busy};
    assign done_w  = {b3.done,  b1.done,  b0.done};
    assign found_w = {b3.found, b1.found, b0.found};
    assign addr_w[0] = b0.address;  assign idx_w[0] = b0.match_idx;
    assign addr_w[1] = b1.address;  assign idx_w[1] = b1.match_idx;
    assign addr_w[2] = b3.address;  assign idx_w[2] = b3.match_idx;

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
    endtask

    // Pulses start (cycle 0) and watches DUT 'sel' until done; optional second start mid-scan.
    task automatic run_scan(input int sel, input logic [15:0] k, input int restart_at,
                            input logic [15:0] k2, output int done_cyc,
                            output logic [15:0] max_addr, output logic [15:0] first_addr);
        int lat;
        int cyc;
        lat      = (sel == 0) ? 0 : ((sel == 1) ? 1 : 3);
        done_cyc = -1;
        max_addr = 16'h0000;
        pres_n   = 0;
        @(posedge clock); #1;
        key   = k;
        start = 1'b1;
        @(posedge clock); #1;
        start      = 1'b0;
        cyc        = 1;
        first_addr = addr_w[sel];
        busy_c1    = busy_w[sel];
        done_c1    = done_w[sel];
        while (cyc < 200 && done_cyc < 0) begin
            if (done_w[sel]) begin
                done_cyc = cyc;
            end else begin
                if (addr_w[sel] > max_addr) max_addr = addr_w[sel];
                if (((cyc - 1) % (lat + 1)) == 0 && pres_n < 16) begin
                    pres_addr[pres_n] = addr_w[sel];
                    pres_n++;
                end
                start = (cyc == restart_at);
                if (cyc == restart_at) key = k2;
                @(posedge clock); #1;
                cyc++;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 200 && busy_w != 3'b000; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        @(posedge clock); #1;
        checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", b1.busy); end
        checks++; if (b1.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", b1.done); end
        checks++; if (b1.found !== 1'b0) begin errors++; $display("FAIL reset_found: got %b expected 0", b1.found); end
        checks++; if (b1.match_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", b1.match_idx); end
        checks++; if (b1.address !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", b1.address); end
        reset = 1'b0;
    endtask

    task automatic test_match();
        int dc; logic [15:0] mx, fa;
        fill_mem();
        run_scan(1, 16'h0005, -1, 16'h0000, dc, mx, fa);
        checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL match_busy_c1: got %b expected 1", busy_c1); end
        checks++; if (dc !== 11) begin errors++; $display("FAIL match_done_cycle: got %0d expected 11", dc); end
        checks++; if (found_w[1] !== 1'b1) begin errors++; $display("FAIL match_found: got %b expected 1", found_w[1]); end
        checks++; if (idx_w[1] !== 4'd4) begin errors++; $display("FAIL match_idx: got %0d expected 4", idx_w[1]); end
        checks++; if (pres_n !== 5) begin errors++; $display("FAIL match_addr_count: got %0d expected 5", pres_n); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (pres_addr[i] !== 16'(2 * i)) begin
                errors++; $display("FAIL match_addr_%0d: got %h expected %h", i, pres_addr[i], 16'(2 * i));
            end
        end
    endtask

    task automatic test_no_match();
        int dc; logic [15:0] mx, fa;
        fill_mem();
        run_scan(1, 16'h00AA, -1, 16'h0000, dc, mx, fa);
        checks++; if (dc !== 33) begin errors++; $display("FAIL nomatch_done_cycle: got %0d expected 33", dc); end
        checks++; if (found_w[1] !== 1'b0) begin errors++; $display("FAIL nomatch_found: got %b expected 0", found_w[1]); end
        checks++; if (addr_w[1] !== 16'h001E) begin errors++; $display("FAIL nomatch_last_addr: got %h expected 001e", addr_w[1]); end
    endtask

    task automatic test_sentinel();
        int dc; logic [15:0] mx, fa;
        fill_mem();
        mem[3] = 16'hFFFF;
        mem[5] = 16'h0009;
        run_scan(1, 16'h0009, -1, 16'h0000, dc, mx, fa);
        checks++; if (dc !== 9) begin errors++; $display("FAIL sent_done_cycle: got %0d expected 9", dc); end
        checks++; if (found_w[1] !== 1'b0) begin errors++; $display("FAIL sent_found: got %b expected 0", found_w[1]); end
        checks++; if (mx !== 16'h0006) begin errors++; $display("FAIL sent_max_addr: got %h expected 0006", mx); end
        fill_mem();
    endtask

    task automatic test_abort();
        int dc; logic [15:0] mx, fa;
        @(posedge clock); #1;
        key = 16'h00AA; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        checks++; if (b1.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_c4: got %b expected 1", b1.busy); end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_c5: got %b expected 0", b1.busy); end
        checks++; if (b1.done !== 1'b0) begin errors++; $display("FAIL abort_done_c5: got %b expected 0", b1.done); end
        run_scan(1, 16'h0005, -1, 16'h0000, dc, mx, fa);
        checks++; if (dc !== 11) begin errors++; $display("FAIL abort_rescan_cycle: got %0d expected 11", dc); end
        checks++; if (found_w[1] !== 1'b1 || idx_w[1] !== 4'd4) begin
            errors++; $display("FAIL abort_rescan_result: got found=%b idx=%0d expected found=1 idx=4", found_w[1], idx_w[1]);
        end
    endtask

    task automatic test_latency();
        int dc; logic [15:0] mx, fa;
        run_scan(0, 16'h0003, -1, 16'h0000, dc, mx, fa);
        checks++; if (dc !== 4) begin errors++; $display("FAIL lat0_done_cycle: got %0d expected 4", dc); end
        checks++; if (found_w[0] !== 1'b1 || idx_w[0] !== 4'd2) begin
            errors++; $display("FAIL lat0_result: got found=%b idx=%0d expected found=1 idx=2", found_w[0], idx_w[0]);
        end
        run_scan(2, 16'h0003, -1, 16'h0000, dc, mx, fa);
        checks++; if (dc !== 13) begin errors++; $display("FAIL lat3_done_cycle: got %0d expected 13", dc); end
        checks++; if (found_w[2] !== 1'b1 || idx_w[2] !== 4'd2) begin
            errors++; $display("FAIL lat3_result: got found=%b idx=%0d expected found=1 idx=2", found_w[2], idx_w[2]);
        end
    endtask

    task automatic test_reset_mid_scan();
        @(posedge clock); #1;
        key = 16'h00AA; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        checks++; if (busy_w !== 3'b000) begin errors++; $display("FAIL rstmid_busy: got %b expected 000", busy_w); end
        checks++; if (b1.address !== 16'h0000) begin errors++; $display("FAIL rstmid_addr: got %h expected 0000", b1.address); end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        checks++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got busy=%b done=%b expected 0 0", b1.busy, b1.done);
        end
    endtask

    task automatic test_back_to_back();
        int dc; logic [15:0] mx, fa;
        // Second start with a different key while busy must not disturb the scan.
        run_scan(1, 16'h0005, 3, 16'h0002, dc, mx, fa);
        checks++; if (dc !== 11 || idx_w[1] !== 4'd4 || found_w[1] !== 1'b1) begin
            errors++; $display("FAIL busy_start: got cycle=%0d found=%b idx=%0d expected 11 1 4", dc, found_w[1], idx_w[1]);
        end
        run_scan(1, 16'h0002, -1, 16'h0000, dc, mx, fa);
        checks++; if (fa !== 16'h0000) begin errors++; $display("FAIL restart_base: got %h expected 0000", fa); end
        checks++; if (done_c1 !== 1'b0) begin errors++; $display("FAIL restart_done_clr: got %b expected 0", done_c1); end
        checks++; if (dc !== 5 || idx_w[1] !== 4'd1) begin
            errors++; $display("FAIL restart_result: got cycle=%0d idx=%0d expected 5 1", dc, idx_w[1]);
        end
        @(posedge clock); #1;
        key = 16'h0007; start = 1'b1; abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        checks++; if (b1.done !== 1'b1 || b1.busy !== 1'b0 || b1.match_idx !== 4'd1) begin
            errors++; $display("FAIL done_start_abort: got done=%b busy=%b idx=%0d expected 1 0 1", b1.done, b1.busy, b1.match_idx);
        end
        key = 16'h0005; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        checks++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin
            errors++; $display("FAIL busy_start_abort: got busy=%b done=%b expected 0 0", b1.busy, b1.done);
        end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_match();
        test_no_match();
        test_sentinel();
        test_abort();
        test_latency();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
